// File: rtl/edge_gen_if.sv
// Request/response bundle for the edge generator: edge requests in, waveform and strobes out.
interface edge_gen_if #(
  parameter int CNT_W = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [CNT_W-1:0] min_hold;
  logic [CNT_W-1:0] pulse_len;
  logic             dout;
  logic             edge_p;
  logic             edge_rise;
  logic             redundant;
  logic             busy;

  // Requester side: issues edge requests, observes the generated waveform.
  modport master (
    output req_valid, req_op, min_hold, pulse_len,
    input  req_ready, dout, edge_p, edge_rise, redundant, busy
  );

  // Generator side.
  modport slave (
    input  req_valid, req_op, min_hold, pulse_len,
    output req_ready, dout, edge_p, edge_rise, redundant, busy
  );
endinterface

// File: rtl/edge_gen.sv
// Edge generator: turns accepted edge requests into a registered single-bit waveform and
// keeps dout stable for min_hold+1 cycles after every edge so downstream sampling never
// merges two edges.
module edge_gen #(
  parameter int   CNT_W      = 8,
  parameter logic INIT_LEVEL = 1'b0
) (
  input logic     clk,
  input logic     srst_n,
  edge_gen_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  localparam logic [1:0]       OP_RISE   = 2'b00;
  localparam logic [1:0]       OP_FALL   = 2'b01;
  localparam logic [1:0]       OP_TOGGLE = 2'b10;
  localparam logic [1:0]       OP_PULSE  = 2'b11;
  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             dout_q, dout_d;
  logic             edge_p_q, edge_p_d;
  logic             edge_rise_q, edge_rise_d;
  logic             redundant_q, redundant_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             accept_s;
  logic             target_s;

  // Ready only when idle and out of reset; accept is the handshake.
  always_comb begin
    bus.req_ready = (state_q == S_IDLE) && srst_n;
    accept_s      = bus.req_valid && bus.req_ready;
  end

  // Next-state and next-output decode; every register keeps its value unless changed below.
  always_comb begin
    state_d     = state_q;
    dout_d      = dout_q;
    edge_p_d    = 1'b0;
    edge_rise_d = edge_rise_q;
    redundant_d = 1'b0;
    hcnt_d      = hcnt_q;
    pcnt_d      = pcnt_q;
    hold_d      = hold_q;
    target_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          case (bus.req_op)
            OP_RISE, OP_FALL: begin
              target_s = (bus.req_op == OP_RISE);
              if (target_s != dout_q) begin
                dout_d      = target_s;
                edge_p_d    = 1'b1;
                edge_rise_d = target_s;
                hcnt_d      = bus.min_hold;
                state_d     = (bus.min_hold != CNT_ZERO) ? S_HOLD : S_IDLE;
              end else begin
                // Level already matches: report it, produce no edge and no hold.
                redundant_d = 1'b1;
              end
            end
            OP_TOGGLE: begin
              dout_d      = ~dout_q;
              edge_p_d    = 1'b1;
              edge_rise_d = ~dout_q;
              hcnt_d      = bus.min_hold;
              state_d     = (bus.min_hold != CNT_ZERO) ? S_HOLD : S_IDLE;
            end
            OP_PULSE: begin
              dout_d      = ~dout_q;
              edge_p_d    = 1'b1;
              edge_rise_d = ~dout_q;
              pcnt_d      = (bus.pulse_len == CNT_ZERO) ? CNT_ONE : bus.pulse_len;
              hold_d      = bus.min_hold;
              state_d     = S_PULSE;
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PULSE: begin
        if (pcnt_q == CNT_ONE) begin
          // Return edge; the hold captured at accept applies from here.
          dout_d      = ~dout_q;
          edge_p_d    = 1'b1;
          edge_rise_d = ~dout_q;
          hcnt_d      = hold_q;
          state_d     = (hold_q != CNT_ZERO) ? S_HOLD : S_IDLE;
        end else begin
          pcnt_d = pcnt_q - CNT_ONE;
        end
      end
      S_HOLD: begin
        if (hcnt_q == CNT_ONE) begin
          state_d = S_IDLE;
        end else begin
          hcnt_d = hcnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any pulse or hold in flight.
  always_ff @(posedge clk or negedge srst_n) begin
    if (!srst_n) begin
      state_q     <= S_IDLE;
      dout_q      <= INIT_LEVEL;
      edge_p_q    <= 1'b0;
      edge_rise_q <= 1'b0;
      redundant_q <= 1'b0;
      hcnt_q      <= CNT_ZERO;
      pcnt_q      <= CNT_ZERO;
      hold_q      <= CNT_ZERO;
    end else begin
      state_q     <= state_d;
      dout_q      <= dout_d;
      edge_p_q    <= edge_p_d;
      edge_rise_q <= edge_rise_d;
      redundant_q <= redundant_d;
      hcnt_q      <= hcnt_d;
      pcnt_q      <= pcnt_d;
      hold_q      <= hold_d;
    end
  end

  // Drive the bus outputs straight from registers.
  always_comb begin
    bus.dout      = dout_q;
    bus.edge_p    = edge_p_q;
    bus.edge_rise = edge_rise_q;
    bus.redundant = redundant_q;
    bus.busy      = (state_q != S_IDLE);
  end

endmodule

// File: tb/tb_edge_gen.sv
// Scoreboard bench for edge_gen: each accepted request is expanded into a timeline of
// expected strobes (cycle, kind, level) plus the cycle the block becomes ready again.
module tb_edge_gen;
  localparam int   CNT_W = 8;
  localparam logic INIT  = 1'b0;

  typedef struct {
    int due;
    bit is_edge;
    bit level;
  } ev_t;

  logic clk = 1'b0;
  logic srst_n = 1'b0;
  always #5 clk = ~clk;

  edge_gen_if #(.CNT_W(CNT_W)) bus ();
  edge_gen #(.CNT_W(CNT_W), .INIT_LEVEL(INIT)) dut (.clk(clk), .srst_n(srst_n), .bus(bus));

  ev_t evq[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  next_free = 0;
  bit  model_level = INIT;
  bit  exp_dout = INIT;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Cycle counter: value seen at a negedge = number of posedges so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares the DUT against the expected timeline and records new accepts.
  always @(negedge clk) begin
    ev_t ev;
    int  e;
    int  p;
    bit  tgt;
    if (!srst_n) begin
      evq.delete();
      next_free   = cyc;
      model_level = INIT;
      exp_dout    = INIT;
      chk("rst_dout", bus.dout, INIT);
      chk("rst_edge_p", bus.edge_p, 0);
      chk("rst_edge_rise", bus.edge_rise, 0);
      chk("rst_redundant", bus.redundant, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_ready", bus.req_ready, 0);
    end else begin
      while (evq.size() > 0 && evq[0].due < cyc) begin
        ev = evq.pop_front();
        chk("event_missed_at", ev.due, cyc);
      end
      if (evq.size() > 0 && evq[0].due == cyc) begin
        ev = evq.pop_front();
        chk("edge_p", bus.edge_p, ev.is_edge);
        chk("redundant", bus.redundant, !ev.is_edge);
        if (ev.is_edge) begin
          chk("edge_rise", bus.edge_rise, ev.level);
          exp_dout = ev.level;
        end
      end else begin
        chk("no_strobe", {bus.edge_p, bus.redundant}, 0);
      end
      chk("dout", bus.dout, exp_dout);
      chk("ready", bus.req_ready, cyc >= next_free);
      chk("busy", bus.busy, cyc < next_free);
      if (bus.req_valid && bus.req_ready) begin
        e = cyc + 1;
        case (bus.req_op)
          2'b00, 2'b01, 2'b10: begin
            tgt = (bus.req_op == 2'b10) ? !model_level : (bus.req_op == 2'b00);
            if (tgt == model_level) begin
              evq.push_back('{due: e, is_edge: 1'b0, level: tgt});
              next_free = e;
            end else begin
              evq.push_back('{due: e, is_edge: 1'b1, level: tgt});
              model_level = tgt;
              next_free = e + int'(bus.min_hold);
            end
          end
          default: begin
            p = (bus.pulse_len == 0) ? 1 : int'(bus.pulse_len);
            evq.push_back('{due: e, is_edge: 1'b1, level: !model_level});
            evq.push_back('{due: e + p, is_edge: 1'b1, level: model_level});
            next_free = e + p + int'(bus.min_hold);
          end
        endcase
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Present a request and keep it valid until the block takes it.
  task automatic issue(input logic [1:0] op, input int mh, input int pl);
    bit done = 1'b0;
    int budget = 0;
    logic [CNT_W-1:0] mh_v = CNT_W'(mh);
    logic [CNT_W-1:0] pl_v = CNT_W'(pl);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.min_hold  = mh_v;
    bus.pulse_len = pl_v;
    while (!done && budget < 2000) begin
      @(negedge clk);
      if (bus.req_ready) done = 1'b1;
      @(posedge clk);
      #2;
      budget++;
    end
    chk("accept_in_time", done, 1);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int b = 0;
    while ((evq.size() > 0 || cyc < next_free) && b < 3000) begin
      step(1);
      b++;
    end
    chk("drain_in_time", b < 3000, 1);
    step(1);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.min_hold  = '0;
    bus.pulse_len = '0;
    srst_n = 1'b0;
    step(3);
    srst_n = 1'b1;
    step(2);

    // Back-to-back toggles with no hold
    repeat (4) issue(2'b10, 0, 0);
    drain();

    // Hold of 3 between a rise and a queued fall
    issue(2'b00, 3, 0);
    issue(2'b01, 3, 0);
    drain();

    // Pulse of 4 cycles followed by a hold of 2
    issue(2'b11, 2, 4);
    issue(2'b00, 0, 0);
    drain();

    // Redundant requests and a zero-length pulse
    issue(2'b00, 0, 0);
    issue(2'b01, 0, 0);
    issue(2'b01, 0, 0);
    issue(2'b11, 0, 0);
    issue(2'b00, 0, 0);
    issue(2'b00, 0, 0);
    drain();

    // min_hold changes while a hold of 7 is running
    issue(2'b01, 7, 0);
    issue(2'b00, 1, 0);
    issue(2'b01, 0, 0);
    drain();

    // Reset two cycles into a 5-cycle pulse
    issue(2'b11, 0, 5);
    step(2);
    srst_n = 1'b0;
    step(2);
    srst_n = 1'b1;
    step(1);
    issue(2'b10, 1, 0);
    drain();

    // Random traffic
    repeat (300) begin
      int mh;
      mh = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 20)) : int'($urandom_range(0, 3));
      issue(2'($urandom_range(0, 3)), mh, int'($urandom_range(0, 6)));
      if ($urandom_range(0, 3) == 0) step(int'($urandom_range(1, 3)));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
